// File: rtl/ptos_nibble_if.sv
`default_nettype none
// ============================================================================
// Module      : ptos_nibble_if
// Description : Signal bundle for the parallel-to-serial nibble transmitter.
//               Carries the nibble source handshake (data / ask_for_data) and
//               the two-wire serial line (scl / sda) plus the busy flag.
// Ports       : master - transmitter side (drives ask/scl/sda/busy, reads data)
//               slave  - source/line side (drives data, observes the rest)
// Revision    : 1.0 - initial release
// ============================================================================
interface ptos_nibble_if;
  logic [3:0] data;          // parallel nibble from the data source
  logic       ask_for_data;  // one-cycle request pulse to the data source
  logic       scl;           // serial clock line, idle high
  logic       sda;           // serial data line, idle high
  logic       busy;          // high while a frame is in progress

  modport master (
    input  data,
    output ask_for_data,
    output scl,
    output sda,
    output busy
  );

  modport slave (
    output data,
    input  ask_for_data,
    input  scl,
    input  sda,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/ptos_nibble.sv
`default_nettype none
// ============================================================================
// Module      : ptos_nibble
// Description : Requests a nibble from a parallel source, then shifts it out
//               MSB first on a two-wire line framed by start/stop conditions.
//               A frame (REQ..STOP_H) is 13 cycles, separated by GAP_CYCLES
//               idle cycles.
// Ports       : sclk - system clock, rising edge active
//               rst  - asynchronous reset, active low
//               bus  - ptos_nibble_if.master (data in; ask_for_data, scl,
//                      sda, busy out; all outputs registered)
// Revision    : 1.0 - initial release
// ============================================================================
module ptos_nibble #(
  parameter int GAP_CYCLES = 2   // idle cycles before each request, 1..15
) (
  input  wire logic           sclk,
  input  wire logic           rst,
  ptos_nibble_if.master       bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    START  = 3'd3,
    BIT_L  = 3'd4,
    BIT_H  = 3'd5,
    STOP_L = 3'd6,
    STOP_H = 3'd7
  } state_e;

  // Last gap count value spent in IDLE; clamped so an out-of-range parameter
  // still yields a usable gap of 1..15 cycles.
  localparam int       c_GAP_CLAMP = (GAP_CYCLES < 1)  ? 1  :
                                     (GAP_CYCLES > 15) ? 15 : GAP_CYCLES;
  localparam logic [3:0] c_GAP_LAST = 4'(c_GAP_CLAMP - 1);
  localparam logic [3:0] c_GAP_MAX  = 4'hF;

  state_e     state_q, state_d;
  logic [3:0] shift_q, shift_d;
  logic [1:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;

  logic       scl_q, scl_d;
  logic       sda_q, sda_d;
  logic       ask_q, ask_d;
  logic       busy_q, busy_d;

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= 4'h0;
      bit_cnt_q <= 2'd0;
      gap_cnt_q <= 4'h0;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      ask_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      scl_q     <= scl_d;
      sda_q     <= sda_d;
      ask_q     <= ask_d;
      busy_q    <= busy_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode.
  // The line outputs are decoded from the current state and registered, so
  // every pin shows the state one cycle after the state register enters it.
  // This keeps the data input off any combinational path to a pin, and the
  // one-cycle lag is what places the first request at edge GAP_CYCLES+1
  // after reset release.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    scl_d     = 1'b1;
    sda_d     = 1'b1;
    ask_d     = 1'b0;
    busy_d    = 1'b1;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (gap_cnt_q != c_GAP_MAX) begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
        if (gap_cnt_q >= c_GAP_LAST) begin
          state_d = REQ;
        end
      end

      REQ: begin
        ask_d   = 1'b1;
        state_d = WAIT;
      end

      // The source answers within one period of the request pulse, so the
      // nibble is stable by the time this state is left.
      WAIT: begin
        shift_d   = bus.data;
        bit_cnt_d = 2'd3;
        state_d   = START;
      end

      // sda falls while scl is high: start condition.
      START: begin
        sda_d   = 1'b0;
        state_d = BIT_L;
      end

      // Data only changes while scl is low.
      BIT_L: begin
        scl_d   = 1'b0;
        sda_d   = shift_q[bit_cnt_q];
        state_d = BIT_H;
      end

      BIT_H: begin
        sda_d = sda_q;
        if (bit_cnt_q == 2'd0) begin
          state_d = STOP_L;
        end else begin
          bit_cnt_d = bit_cnt_q - 2'd1;
          state_d   = BIT_L;
        end
      end

      STOP_L: begin
        scl_d   = 1'b0;
        sda_d   = 1'b0;
        state_d = STOP_H;
      end

      // Leaving here releases sda while scl stays high: stop condition.
      STOP_H: begin
        sda_d     = 1'b0;
        gap_cnt_d = 4'h0;
        state_d   = IDLE;
      end

      default: begin
        busy_d    = 1'b0;
        gap_cnt_d = 4'h0;
        state_d   = IDLE;
      end
    endcase
  end

  assign bus.scl          = scl_q;
  assign bus.sda          = sda_q;
  assign bus.ask_for_data = ask_q;
  assign bus.busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ptos_nibble.sv
`default_nettype none
// ============================================================================
// Module      : tb_ptos_nibble
// Description : Self-checking bench for ptos_nibble. A data source answers each
//               request and queues the nibble it presented; a line monitor
//               rebuilds every 13-cycle frame from the pins and compares it
//               with the waveform implied by the queued nibble.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ptos_nibble;

  localparam int GAP = 2;
  localparam int FRAME_LEN = 13;

  localparam int M_INC    = 0;  // source increments after each request
  localparam int M_CONST  = 1;  // source holds 4'b1010
  localparam int M_TOGGLE = 2;  // random on request, toggles F/0 otherwise
  localparam int M_RAND   = 3;  // random on request, random garbage otherwise

  // scl per frame position REQ..STOP_H
  localparam logic [12:0] c_SCL_FRAME  = 13'b1110101010101;
  localparam logic [12:0] c_BUSY_FRAME = 13'b1111111111111;
  localparam logic [12:0] c_ASK_FRAME  = 13'b1000000000000;

  logic sclk = 1'b0;
  logic rst  = 1'b0;

  ptos_nibble_if bus ();

  ptos_nibble #(.GAP_CYCLES(GAP)) dut (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bus.master)
  );

  always #5 sclk = ~sclk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         mode    = M_INC;
  logic [3:0] src_val = 4'h0;
  logic [3:0] exp_q[$];
  int         cyc = 0;
  int         frames_done = 0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line waveform for one frame: REQ, WAIT idle-high, START drops sda, each
  // bit held across a low and a high scl phase MSB first, then both stop
  // phases hold sda low.
  function automatic logic [12:0] exp_sda_frame(input logic [3:0] n);
    logic [12:0] v;
    v = '0;
    v[12] = 1'b1;          // REQ
    v[11] = 1'b1;          // WAIT
    v[10] = 1'b0;          // START
    for (int k = 0; k < 4; k++) begin
      v[12 - (3 + 2*k)] = n[3 - k];
      v[12 - (4 + 2*k)] = n[3 - k];
    end
    return v;              // STOP_L / STOP_H stay 0
  endfunction

  // Rising edges since reset release
  always @(posedge sclk or negedge rst) begin
    if (!rst) cyc = 0;
    else      cyc = cyc + 1;
  end

  // Data source: presents the next nibble on each request and queues it.
  always @(negedge sclk) begin
    if (!rst) begin
      exp_q.delete();
      bus.data = src_val;
    end else if (bus.ask_for_data) begin
      case (mode)
        M_INC:   src_val = src_val + 4'd1;
        M_CONST: src_val = 4'hA;
        default: src_val = 4'($urandom_range(0, 15));
      endcase
      bus.data = src_val;
      exp_q.push_back(src_val);
    end else begin
      case (mode)
        M_TOGGLE: bus.data = (bus.data == 4'hF) ? 4'h0 : 4'hF;
        M_RAND:   bus.data = 4'($urandom_range(0, 15));
        default:  bus.data = src_val;
      endcase
    end
  end

  // Line monitor
  bit          in_frame = 1'b0;
  bit          post_frame = 1'b0;
  bit          first_after_rst = 1'b1;
  bit          have_last = 1'b0;
  int          last_ask = 0;
  int          pos = 0;
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  logic [12:0] scl_v, sda_v, busy_v, ask_v;

  always @(negedge sclk) begin
    logic [3:0] n;
    bit         legal;
    if (!rst) begin
      in_frame        = 1'b0;
      post_frame      = 1'b0;
      first_after_rst = 1'b1;
      have_last       = 1'b0;
      prev_scl        = 1'b1;
      prev_sda        = 1'b1;
    end else begin
      if (bus.ask_for_data && !in_frame) begin
        if (first_after_rst)
          check(cyc == GAP + 1, "first_ask_edge", cyc, GAP + 1);
        else if (have_last)
          check(cyc - last_ask == FRAME_LEN + GAP, "ask_spacing", cyc - last_ask, FRAME_LEN + GAP);
        first_after_rst = 1'b0;
        have_last       = 1'b1;
        last_ask        = cyc;
        in_frame        = 1'b1;
        pos             = 0;
        scl_v = '0; sda_v = '0; busy_v = '0; ask_v = '0;
      end

      // sda may move under a high scl only at START or at the stop release.
      if (prev_scl && bus.scl && (bus.sda !== prev_sda)) begin
        legal = (in_frame && pos == 2 && !bus.sda) || (post_frame && bus.sda);
        check(legal, "sda_edge_while_scl_high", pos, 2);
      end

      if (post_frame) begin
        check({bus.ask_for_data, bus.busy, bus.scl, bus.sda} == 4'b0011,
              "idle_after_stop", {bus.ask_for_data, bus.busy, bus.scl, bus.sda}, 4'b0011);
        post_frame = 1'b0;
      end

      if (in_frame) begin
        scl_v[12 - pos]  = bus.scl;
        sda_v[12 - pos]  = bus.sda;
        busy_v[12 - pos] = bus.busy;
        ask_v[12 - pos]  = bus.ask_for_data;
        pos++;
        if (pos == FRAME_LEN) begin
          in_frame   = 1'b0;
          post_frame = 1'b1;
          frames_done++;
          if (exp_q.size() == 0) begin
            check(1'b0, "frame_without_request", 0, 1);
          end else begin
            n = exp_q.pop_front();
            check(scl_v == c_SCL_FRAME, "frame_scl", scl_v, c_SCL_FRAME);
            check(sda_v == exp_sda_frame(n), "frame_sda_nibble", sda_v, exp_sda_frame(n));
            check(busy_v == c_BUSY_FRAME, "frame_busy", busy_v, c_BUSY_FRAME);
            check(ask_v == c_ASK_FRAME, "frame_ask_pulse", ask_v, c_ASK_FRAME);
          end
        end
      end
    end
    prev_scl = bus.scl;
    prev_sda = bus.sda;
  end

  // Main sequence
  initial begin
    bit got;
    rst  = 1'b0;
    mode = M_INC;
    repeat (2) @(negedge sclk);
    #1;
    check({bus.ask_for_data, bus.busy, bus.scl, bus.sda} == 4'b0011,
          "reset_outputs", {bus.ask_for_data, bus.busy, bus.scl, bus.sda}, 4'b0011);
    #1 rst = 1'b1;

    repeat (1000) @(negedge sclk);
    #1 mode = M_CONST;
    repeat (100) @(negedge sclk);
    #1 mode = M_TOGGLE;
    repeat (150) @(negedge sclk);
    #1 mode = M_RAND;
    repeat (150) @(negedge sclk);
    #1 mode = M_INC;

    // Abort a frame during the high phase of the second bit.
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge sclk);
      #1 got = bus.ask_for_data;
    end
    check(got, "ask_before_abort", got, 1);
    if (got) begin
      repeat (6) @(posedge sclk);
      #2;
      check({bus.busy, bus.scl} == 2'b11, "pre_abort_bit_h", {bus.busy, bus.scl}, 2'b11);
      rst = 1'b0;
      #1;
      check({bus.ask_for_data, bus.busy, bus.scl, bus.sda} == 4'b0011,
            "async_abort_outputs", {bus.ask_for_data, bus.busy, bus.scl, bus.sda}, 4'b0011);
      repeat (3) @(negedge sclk);
      #2 rst = 1'b1;
    end

    repeat (100) @(negedge sclk);
    #1;
    check(frames_done >= 90, "frames_observed", frames_done, 90);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ptos_nibble.md
PTOS_NIBBLE -- requirements
Module: ptos_nibble

Interface
REQ-001 Parameter: GAP_CYCLES, default 2, number of idle cycles (scl=1, sda=1) before each request, including the first one after reset; legal range 1..15.
REQ-002 Port: sclk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port: data  input  4  parallel nibble from the data source.
REQ-005 Port: ask_for_data  output  1  request pulse to the data source; the source presents the next nibble within one sclk period of the rising edge.
REQ-006 Port: scl  output  1  serial clock line; idle high.
REQ-007 Port: sda  output  1  serial data line; idle high.
REQ-008 Port: busy  output  1  high while a frame is in progress.

Function
REQ-009 All outputs SHALL be registered on rising sclk; no combinational path from data to any output.
REQ-010 FSM states SHALL be IDLE, REQ, WAIT, START, BIT_L, BIT_H, STOP_L, STOP_H.
REQ-011 IDLE: scl=1, sda=1, ask_for_data=0, busy=0; gap counter counts GAP_CYCLES cycles, then -> REQ.
REQ-012 REQ: ask_for_data=1 for exactly one cycle, busy=1, scl=1, sda=1; -> WAIT.
REQ-013 WAIT: ask_for_data=0, scl=1, sda=1; on exit, data[3:0] SHALL be captured into a 4-bit shift register; bit counter loaded with 3; -> START.
REQ-014 START: scl=1, sda=0 (falling sda while scl high); -> BIT_L.
REQ-015 BIT_L: scl=0, sda=shift[bit counter]; -> BIT_H.
REQ-016 BIT_H: scl=1, sda unchanged from BIT_L; if bit counter=0 -> STOP_L, else decrement counter and -> BIT_L.
REQ-017 Bits SHALL be sent MSB first (data[3] first, data[0] last); sda SHALL change only while scl=0, except at START and at the STOP release.
REQ-018 STOP_L: scl=0, sda=0; -> STOP_H.
REQ-019 STOP_H: scl=1, sda=0; -> IDLE, where sda returns to 1 while scl stays 1 (stop condition).
REQ-020 Frame length from REQ through STOP_H SHALL be exactly 13 cycles; the period between successive ask_for_data pulses SHALL be 13+GAP_CYCLES cycles.
REQ-021 busy SHALL be 1 in REQ through STOP_H and 0 in IDLE.
REQ-022 data SHALL be sampled only once per frame (at WAIT exit); changes to data at any other time SHALL have no effect on sda.
REQ-023 The bit counter SHALL be 2 bits, with no wrap beyond 0; the gap counter SHALL saturate and reload with 0 on entry to IDLE.

Reset
REQ-024 While rst=0, the block SHALL force, asynchronously: state=IDLE, scl=1, sda=1, ask_for_data=0, busy=0, shift=0, bit counter=0, gap counter=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately with no stop condition, and the captured nibble SHALL be discarded.
REQ-026 After rst rises, the first ask_for_data pulse SHALL occur at the GAP_CYCLES+1th rising edge, starting a fresh frame.

Verification
REQ-027 Reset then release, GAP_CYCLES=2, source starts at 0 and increments after each ask -> ask_for_data high for 1 cycle at edge 3; first frame sda bits 0,0,0,1; second frame 0,0,1,0.
REQ-028 data=4'b1010 held constant -> per frame scl sequence 1,1,1,0,1,0,1,0,1,0,1,0,1 (REQ..STOP_H) and sda bits 1,0,1,0; start and stop conditions present.
REQ-029 data toggled between 4'hF and 4'h0 every cycle during BIT states -> transmitted nibble equals the value present at WAIT exit only.
REQ-030 rst driven low during BIT_H of bit 2 -> scl=1, sda=1, busy=0 without waiting for an edge; after release the next frame carries a newly requested nibble.
REQ-031 Run 1000 sclk cycles with an incrementing source -> ask_for_data pulse spacing always 15 cycles; decoded nibbles sequential mod 16 (wrap 4'hF -> 4'h0 transmitted correctly); checker flags any sda change while scl=1 other than START/STOP.
